// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, byte-lane indices and checksum width.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_WRITE   = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  // Byte lanes within a packed word; lane 0 is the first (most significant) byte.
  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  localparam int CSUM_WIDTH = 8;

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_bytes(state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_PAYLOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs stream bytes big-endian into a 32-bit word and tracks which lane the
// next byte lands in. word_full flags a completed word until the next byte.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        last_lane,
  output logic        word_full
);

  logic [31:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;
  logic        full_q, full_d;

  // Next-state logic: shift the byte in from the right so the first byte ends up in [31:24].
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    word_d = word_q;
    lane_d = lane_q;
    full_d = full_q;
    if (clr) begin
      word_d = '0;
      lane_d = LANE_FIRST;
      full_d = 1'b0;
    end else if (byte_valid) begin
      word_d = {word_q[23:0], byte_in};
      lane_d = lane_q + 2'd1;
      full_d = (lane_q == LANE_LAST);
    end
  end

  // Pack register, lane counter and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      word_q <= '0;
      lane_q <= LANE_FIRST;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
      full_q <= full_d;
    end
  end

  assign word_next = {word_q[23:0], byte_in};
  assign last_lane = (lane_q == LANE_LAST);
  assign word_full = full_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed byte stream,
// writes packed words, verifies a trailing XOR checksum and releases the CPU
// from reset only after a clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        InValid,
  input  logic [7:0]  InData,
  output logic        InReady,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordsWritten
);

  // Largest word count the memory can hold; one bit wider than the length field.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             words_q, words_d;
  logic [CSUM_WIDTH-1:0]   csum_q, csum_d;
  logic                    in_ready_q, in_ready_d;
  logic                    mem_write_q, mem_write_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    cpu_hold_q, cpu_hold_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic                    pk_clr;
  logic                    pk_valid;
  logic [31:0]             pk_word_next;
  logic                    pk_last_lane;
  logic                    pk_word_full;
  logic [15:0]             len_rx;

  imem_loader_word_packer u_packer (
    .clk        (Clk),
    .rst_n      (Reset),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_in    (InData),
    .word_next  (pk_word_next),
    .last_lane  (pk_last_lane),
    .word_full  (pk_word_full)
  );

  // A byte moves only when the registered ready meets a valid byte.
  assign accept = InValid && in_ready_q;
  assign len_rx = {len_q[15:8], InData};

  // Next-state and next-output logic for the load sequence.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    words_d     = words_q;
    csum_d      = csum_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    error_d     = error_q;
    pk_clr      = 1'b0;
    pk_valid    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (Start) begin
          state_d    = ST_LEN_HI;
          len_d      = '0;
          words_d    = '0;
          csum_d     = '0;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          pk_clr     = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = InData;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_rx;
          if ({1'b0, len_rx} > CAPACITY) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else if (len_rx == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          pk_valid = 1'b1;
          csum_d   = csum_q ^ InData;
          if (pk_last_lane) begin
            // Launch the write with the completed word so it appears during WRITE.
            state_d     = ST_WRITE;
            mem_write_d = 1'b1;
            mem_addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
            mem_wdata_d = pk_word_next;
          end
        end
      end
      ST_WRITE: begin
        // The packer always reports a full word here; the count follows it.
        if (pk_word_full) begin
          words_d = words_q + 16'd1;
        end
        state_d = (words_d == len_q) ? ST_CHECK : ST_PAYLOAD;
      end
      ST_CHECK: begin
        if (accept) begin
          if (InData == csum_q) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = accepts_bytes(state_d);
  end

  // Single state register for the FSM and all of its registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      words_q     <= '0;
      csum_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      words_q     <= words_d;
      csum_q      <= csum_d;
      in_ready_q  <= in_ready_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign InReady      = in_ready_q;
  assign MemWrite     = mem_write_q;
  assign MemAddr      = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign CpuHold      = cpu_hold_q;
  assign Done         = done_q;
  assign Error        = error_q;
  assign WordsWritten = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed streams plus randomized loads
// with random valid gaps, compared against a stream-level reference model.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          CAP_WORDS = 256;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        InValid = 1'b0;
  logic [7:0]  InData = 8'h00;
  logic        InReady;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [15:0] WordsWritten;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [63:0] got[$];
  logic [63:0] exp_writes[$];
  logic        exp_done;
  logic        exp_err;
  logic [15:0] exp_words;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(BASE)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .InValid      (InValid),
    .InData       (InData),
    .InReady      (InReady),
    .MemWrite     (MemWrite),
    .MemAddr      (MemAddr),
    .MemWriteData (MemWriteData),
    .CpuHold      (CpuHold),
    .Done         (Done),
    .Error        (Error),
    .WordsWritten (WordsWritten)
  );

  always #5 Clk = ~Clk;

  // Record every write seen while out of reset.
  always @(negedge Clk) begin
    if (Reset && MemWrite) got.push_back({MemAddr, MemWriteData});
  end

  // Reference model: derive writes and final outcome from the stream alone.
  task automatic build_expect();
    int n;
    logic [7:0] csum;
    exp_writes.delete();
    n = int'({stream[0], stream[1]});
    if (n > CAP_WORDS) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_words = 16'd0;
    end else begin
      csum = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_writes.push_back({BASE + 32'(4 * i),
                              stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
        for (int k = 0; k < 4; k++) csum = csum ^ stream[2+4*i+k];
      end
      exp_done  = (stream[2+4*n] == csum);
      exp_err   = !exp_done;
      exp_words = 16'(n);
    end
  endtask

  task automatic start_load();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Drive the first n_send stream bytes, inserting idle cycles with probability gap_pct.
  task automatic send_stream(input int gap_pct, input int n_send);
    int idx = 0;
    int budget = 4000;
    int n_len = int'({stream[0], stream[1]});
    bit pending = 0;
    bit will_accept;
    bit valid;
    while (idx < n_send && budget > 0) begin
      @(negedge Clk);
      if (pending) begin
        checks++;
        if (MemWrite !== 1'b1) begin
          errors++;
          $display("FAIL write_latency idx=%0d got MemWrite=%b want 1", idx, MemWrite);
        end
        pending = 0;
      end
      valid = ($urandom_range(99) >= gap_pct);
      InValid = valid;
      InData = valid ? stream[idx] : 8'($urandom);
      will_accept = valid && InReady;
      @(posedge Clk);
      if (will_accept) begin
        if (idx >= 2 && n_len <= CAP_WORDS && (idx - 2) < 4 * n_len && ((idx - 2) % 4) == 3)
          pending = 1;
        idx++;
      end
      budget--;
    end
    @(negedge Clk);
    InValid = 1'b0;
    if (pending) begin
      checks++;
      if (MemWrite !== 1'b1) begin
        errors++;
        $display("FAIL write_latency idx=%0d got MemWrite=%b want 1", idx, MemWrite);
      end
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout sent %0d of %0d bytes", idx, n_send);
    end
  endtask

  task automatic check_outcome(input string name);
    checks++;
    if (got.size() != exp_writes.size()) begin
      errors++;
      $display("FAIL %s write_count got %0d want %0d", name, got.size(), exp_writes.size());
    end
    for (int i = 0; i < exp_writes.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_writes[i]) begin
        errors++;
        $display("FAIL %s write%0d got addr=%h data=%h want addr=%h data=%h", name, i,
                 got[i][63:32], got[i][31:0], exp_writes[i][63:32], exp_writes[i][31:0]);
      end
    end
    checks++;
    if ({Done, Error, CpuHold, InReady, MemWrite} !== {exp_done, exp_err, !exp_done, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s status got D/E/H/R/W=%b%b%b%b%b want %b%b%b00", name,
               Done, Error, CpuHold, InReady, MemWrite, exp_done, exp_err, !exp_done);
    end
    checks++;
    if (WordsWritten !== exp_words) begin
      errors++;
      $display("FAIL %s words_written got %0d want %0d", name, WordsWritten, exp_words);
    end
  endtask

  task automatic run_load(input string name, input int gap_pct);
    got.delete();
    build_expect();
    start_load();
    send_stream(gap_pct, stream.size());
    repeat (2) @(negedge Clk);
    check_outcome(name);
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({CpuHold, Done, Error, MemWrite, InReady} !== 5'b10000 ||
        MemAddr !== 32'h0 || MemWriteData !== 32'h0 || WordsWritten !== 16'h0) begin
      errors++;
      $display("FAIL %s got H/D/E/W/R=%b%b%b%b%b addr=%h data=%h words=%0d want 10000 0 0 0",
               name, CpuHold, Done, Error, MemWrite, InReady, MemAddr, MemWriteData, WordsWritten);
    end
  endtask

  task automatic set_good(input logic [7:0] last);
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, last};
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_values("reset");
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_good();
    set_good(8'h2A);
    run_load("good", 0);
  endtask

  task automatic test_bad_checksum();
    set_good(8'h2B);
    run_load("bad_checksum", 0);
  endtask

  task automatic test_empty();
    stream = '{8'h00, 8'h00, 8'h00};
    run_load("empty", 0);
  endtask

  task automatic test_oversize();
    stream = '{8'h01, 8'h01};
    run_load("oversize", 0);
  endtask

  task automatic test_stalls();
    set_good(8'h2A);
    run_load("stalls", 50);
  endtask

  task automatic test_reset_mid_load();
    set_good(8'h2A);
    start_load();
    send_stream(30, 7);
    Reset = 1'b0;
    @(negedge Clk);
    check_reset_values("reset_mid_load");
    Reset = 1'b1;
    @(negedge Clk);
    run_load("after_mid_reset", 20);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(1, 6);
      logic [7:0] csum = 8'h00;
      logic [7:0] b;
      stream.delete();
      stream.push_back(8'h00);
      stream.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        csum = csum ^ b;
        stream.push_back(b);
      end
      stream.push_back(($urandom_range(1) == 1) ? csum : (csum ^ 8'(1 << $urandom_range(7))));
      run_load($sformatf("random%0d", t), $urandom_range(0, 50));
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_checksum();
    test_empty();
    test_oversize();
    test_stalls();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the processor's instruction memory, sitting opposite the CPU's read-only instruction-fetch port. It receives a length-prefixed byte stream over a valid/ready handshake and packs the bytes into 32-bit words. It issues one-cycle word writes to instruction memory, verifies a trailing XOR checksum, and holds the CPU in reset until a load completes cleanly.

Parameters:
ADDR_WIDTH, 8, word-address bits of instruction memory; capacity = 2^ADDR_WIDTH words
BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word aligned

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  single-cycle pulse that begins a load
InValid  input  1  byte on InData is valid
InData  input  8  stream byte
InReady  output  1  loader accepts the byte this cycle
MemWrite  output  1  instruction-memory write strobe, one cycle per word
MemAddr  output  32  byte address of the write; always word aligned
MemWriteData  output  32  packed word
CpuHold  output  1  drives CPU reset; 1 = hold CPU
Done  output  1  load finished and checksum matched
Error  output  1  load failed (oversize or checksum mismatch)
WordsWritten  output  16  number of words written in the current or last load

Behaviour:
- Reset asserted (Reset=0):
  - state IDLE; CpuHold=1
  - Done=0, Error=0, MemWrite=0, InReady=0
  - MemAddr=0, MemWriteData=0, WordsWritten=0
  - checksum and byte counters cleared
- Byte accept: InValid && InReady at a rising Clk edge. InReady does not depend combinationally on InValid.
- FSM states: IDLE, LEN_HI, LEN_LO, PAYLOAD, WRITE, CHECK, DONE, ERR.
- IDLE/DONE/ERR, on Start:
  - go to LEN_HI
  - clear Done, Error, WordsWritten, checksum, byte index
  - set CpuHold=1
- Start in any other state is ignored.
- InReady=1 only in LEN_HI, LEN_LO, PAYLOAD and CHECK.
- LEN_HI: accepted byte -> N[15:8]. LEN_LO: accepted byte -> N[7:0]. After LEN_LO:
  - N > 2^ADDR_WIDTH -> ERR
  - N == 0 -> CHECK
  - otherwise -> PAYLOAD
- PAYLOAD:
  - Bytes are packed big-endian: first byte -> [31:24], fourth byte -> [7:0].
  - Each accepted payload byte is XORed into an 8-bit running checksum.
  - The length bytes are not included in the checksum.
  - After the 4th byte of a word is accepted -> WRITE.
- WRITE (exactly one cycle):
  - MemWrite=1, MemAddr = BASE_ADDR + 4*WordsWritten, MemWriteData = packed word
  - WordsWritten increments at the end of the cycle
  - if the incremented count == N -> CHECK, else -> PAYLOAD
- Latency and throughput:
  - MemWrite is asserted in the cycle after the 4th byte's accept edge.
  - Peak throughput is 4 bytes per 5 cycles.
- CHECK: accept one byte. If it equals the running checksum -> DONE, otherwise -> ERR.
- DONE: Done=1, CpuHold=0; held until the next Start.
- ERR: Error=1, CpuHold=1; held until the next Start. Words already written are not rolled back.
- MemWrite=0 in every state except WRITE. MemAddr and MemWriteData hold their last values outside WRITE.
- Gaps in InValid stall the FSM in its current state with no side effects.
- Reset mid-load: immediate return to reset values. A partial word is discarded.

Decomposition:
- Shared header loader_defs.vh holds:
  - FSM state encodings (3-bit localparams)
  - byte-lane index constants
  - the checksum width
- One natural sub-module, loader_word_packer:
  - 4-byte shift/pack register with lane counter and word_full flag
  - cleared on Start and on reset
- The top-level FSM owns the length, address and checksum registers.

Test Plan:
1. Reset: hold Reset=0 -> CpuHold=1, Done=0, Error=0, MemWrite=0, InReady=0, MemAddr=0, WordsWritten=0.
2. Good load: Start, stream 00 02 12 34 56 78 DE AD BE EF 2A.
   - MemWrite at addr 0x0 with data 0x12345678, then at addr 0x4 with data 0xDEADBEEF.
   - Then Done=1, CpuHold=0, WordsWritten=2.
3. Bad checksum: same stream with last byte 2B.
   - Both writes still occur.
   - Then Error=1, Done=0, CpuHold=1.
4. Empty load: Start, stream 00 00 00 -> no MemWrite; Done=1, CpuHold=0, WordsWritten=0.
5. Oversize: ADDR_WIDTH=8, stream 01 01 -> Error=1 after the LEN_LO accept, InReady=0, no MemWrite.
6. Stalls and reset mid-load: random InValid gaps on the good stream give identical writes. Then:
   - Assert Reset after 5 payload bytes -> all outputs return to reset values.
   - A following Start plus the full good stream -> Done=1 with correct writes.
